// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the square-and-multiply modular exponentiation controller.
// The operation-count helper below also covers the MOD_EXP_CONST_TIME_EN build.
package mod_exp_pkg;

  localparam int NBITS_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQR,
    MUL,
    FIN
  } state_t;

  // Number of multiplier requests for one job with modulus != 0.
  function automatic int unsigned op_count(input int unsigned ebits,
                                           input int unsigned ones,
                                           input bit          const_time);
    return const_time ? (1 + 2 * ebits) : (1 + ebits + ones);
  endfunction

endpackage

// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply controller computing base^exp mod m through an external modular multiplier.
// Optional feature: define MOD_EXP_CONST_TIME_EN to run a MUL after every SQR (exp-independent timing).
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int EBITS = NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             err,
  output logic             done_irq_p,
  output logic             mm_enable_p,
  output logic [NBITS-1:0] mm_a,
  output logic [NBITS-1:0] mm_b,
  output logic [NBITS-1:0] mm_m,
  input  logic [NBITS-1:0] mm_y,
  input  logic             mm_done_p
);

  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;

  state_t           state;
  logic [NBITS-1:0] r;
  logic [NBITS-1:0] bred;
  logic [EBITS-1:0] exp_lat;
  logic [IW-1:0]    idx;

  logic             last_bit;
  logic             go_mul;
  logic             keep_r;
  logic [NBITS-1:0] r_new;

  always_comb begin
    last_bit = (idx == '0);
`ifdef MOD_EXP_CONST_TIME_EN
    go_mul = 1'b1;
    // Dummy multiply for a zero exponent bit: product is discarded.
    keep_r = (state == MUL) && !exp_lat[idx];
`else
    go_mul = exp_lat[idx];
    keep_r = 1'b0;
`endif
    r_new = keep_r ? r : mm_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      result      <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done_irq_p  <= 1'b0;
      mm_enable_p <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
      mm_m        <= '0;
      r           <= '0;
      bred        <= '0;
      exp_lat     <= '0;
      idx         <= '0;
    end else begin
      mm_enable_p <= 1'b0;
      done_irq_p  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_p) begin
            if (m == '0) begin
              err        <= 1'b1;
              result     <= '0;
              done_irq_p <= 1'b1;
              state      <= FIN;
            end else begin
              err         <= 1'b0;
              exp_lat     <= exp;
              mm_m        <= m;
              r           <= NBITS'(1);
              idx         <= IW'(EBITS - 1);
              mm_a        <= base;
              mm_b        <= NBITS'(1);
              mm_enable_p <= 1'b1;
              busy        <= 1'b1;
              state       <= REDUCE;
            end
          end
        end
        REDUCE: begin
          if (mm_done_p) begin
            bred        <= mm_y;
            mm_a        <= r;
            mm_b        <= r;
            mm_enable_p <= 1'b1;
            state       <= SQR;
          end
        end
        SQR: begin
          if (mm_done_p) begin
            r <= mm_y;
            if (go_mul) begin
              mm_a        <= mm_y;
              mm_b        <= bred;
              mm_enable_p <= 1'b1;
              state       <= MUL;
            end else if (last_bit) begin
              result     <= mm_y;
              done_irq_p <= 1'b1;
              busy       <= 1'b0;
              state      <= FIN;
            end else begin
              idx         <= idx - 1'b1;
              mm_a        <= mm_y;
              mm_b        <= mm_y;
              mm_enable_p <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mm_done_p) begin
            r <= r_new;
            if (last_bit) begin
              result     <= r_new;
              done_irq_p <= 1'b1;
              busy       <= 1'b0;
              state      <= FIN;
            end else begin
              idx         <= idx - 1'b1;
              mm_a        <= r_new;
              mm_b        <= r_new;
              mm_enable_p <= 1'b1;
              state       <= SQR;
            end
          end
        end
        // Completion was flagged on entry; this cycle carries the done pulse.
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: fixed-latency multiplier model plus right-to-left modexp reference.
// Honours MOD_EXP_CONST_TIME_EN for the expected multiplier request count.
module tb_mod_exp_ctrl;
  import mod_exp_pkg::*;

  localparam int N = 256;
  localparam int L = 3;
`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_p = 1'b0;
  logic [N-1:0] b_in = '0;
  logic [N-1:0] e_in = '0;
  logic [N-1:0] m_in = '0;
  logic [N-1:0] result;
  logic         busy, err, done_irq_p, mm_enable_p;
  logic [N-1:0] mm_a, mm_b, mm_m, mm_y;
  logic         mm_done_p;

  logic         model_done = 1'b0;
  logic [N-1:0] model_y = '0;
  logic         inj_done = 1'b0;
  logic [N-1:0] inj_y = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_count = 0;
  int last_done_cyc = -1;

  mod_exp_ctrl #(.NBITS(N), .EBITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p),
    .base(b_in), .exp(e_in), .m(m_in),
    .result(result), .busy(busy), .err(err), .done_irq_p(done_irq_p),
    .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_y(mm_y), .mm_done_p(mm_done_p)
  );

  always #5 clk = ~clk;

  assign mm_done_p = model_done | inj_done;
  assign mm_y      = inj_done ? inj_y : model_y;

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] mm);
    logic [2*N-1:0] p;
    if (mm == '0) return '0;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    p = p % {{N{1'b0}}, mm};
    return p[N-1:0];
  endfunction

  // Right-to-left binary exponentiation, independent of the controller's bit order.
  function automatic logic [N-1:0] ref_modexp(input logic [N-1:0] b, input logic [N-1:0] e,
                                              input logic [N-1:0] mm);
    logic [N-1:0] acc, sq;
    if (mm == '0) return '0;
    acc = (mm == N'(1)) ? '0 : N'(1);
    sq  = mulmod(b, N'(1), mm);
    for (int i = 0; i < N; i++) begin
      if (e[i]) acc = mulmod(acc, sq, mm);
      sq = mulmod(sq, sq, mm);
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Fixed-latency multiplier: product appears L cycles after the request cycle.
  logic         pend = 1'b0;
  int           lat_cnt = 0;
  logic [N-1:0] cap_a, cap_b, cap_m;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (mm_enable_p) begin
      pend    <= 1'b1;
      lat_cnt <= L - 1;
      cap_a   <= mm_a;
      cap_b   <= mm_b;
      cap_m   <= mm_m;
    end else if (pend) begin
      if (lat_cnt == 1) begin
        model_done <= 1'b1;
        model_y    <= mulmod(cap_a, cap_b, cap_m);
        pend       <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (mm_enable_p) en_count++;
    if (mm_done_p) last_done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_job(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] mm,
                        input string tag, input int intr, output int ops);
    logic [N-1:0] expres;
    int           exp_ops, ops0;
    bit           seen;
    expres  = ref_modexp(b, e, mm);
    exp_ops = (mm == '0) ? 0 : int'(op_count(N, $countones(e), CT));
    @(negedge clk);
    b_in = b; e_in = e; m_in = mm; start_p = 1'b1;
    ops0 = en_count;
    @(negedge clk);
    start_p = 1'b0;
    if (mm == '0) begin
      check({tag, ".done_t1"}, done_irq_p, 1'b1);
      check({tag, ".err"}, err, 1'b1);
      check({tag, ".result"}, result, '0);
      check({tag, ".busy"}, busy, 1'b0);
    end else begin
      check({tag, ".busy_t1"}, busy, 1'b1);
      check({tag, ".req_t1"}, mm_enable_p, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 5000 && !seen; k++) begin
        @(negedge clk);
        if (done_irq_p) seen = 1'b1;
        if (k == intr) begin
          start_p = 1'b1; b_in = ~b; e_in = ~e; m_in = mm + N'(3);
        end else begin
          start_p = 1'b0;
        end
      end
      start_p = 1'b0;
      check({tag, ".done_seen"}, seen, 1'b1);
      check({tag, ".result"}, result, expres);
      check({tag, ".err"}, err, 1'b0);
      check({tag, ".busy_at_done"}, busy, 1'b0);
      check({tag, ".done_after_last_mm"}, (cyc == last_done_cyc), 1'b1);
    end
    ops = en_count - ops0;
    check({tag, ".op_count"}, ops, exp_ops);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, done_irq_p, 1'b0);
    $display("job %s: base=%0h exp=%0h m=%0h result=%0h ops=%0d", tag, b, e, mm, result, ops);
  endtask

  initial begin
    int           ops;
    logic [N-1:0] saved, rb, re, rm;
    bit           bad;

    repeat (2) @(negedge clk);
    check("rst.result", result, '0);
    check("rst.busy", busy, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.done", done_irq_p, 1'b0);
    check("rst.mm_enable", mm_enable_p, 1'b0);
    check("rst.mm_a", mm_a, '0);
    rst_n = 1'b1;

    do_job(N'(4), N'(13), N'(497), "kat", -1, ops);
    check("kat.value", result, N'(445));
    check("kat.ops_const", ops, CT ? 513 : 260);

    do_job(N'(15), N'(2), N'(10), "unreduced", -1, ops);
    check("unreduced.value", result, N'(5));
    do_job(rand_n(), '0, N'(10), "exp0", -1, ops);
    check("exp0.value", result, N'(1));
    do_job(N'(7), N'(5), N'(1), "mod1", -1, ops);
    check("mod1.value", result, '0);
    do_job(rand_n(), rand_n(), '0, "mod0", -1, ops);

    rb = rand_n(); re = rand_n(); rm = rand_n() | N'(1);
    do_job(rb, re, rm, "start_while_busy", 50, ops);

    saved = result;
    @(negedge clk);
    inj_done = 1'b1; inj_y = rand_n();
    @(negedge clk);
    inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check("spurious.result", result, saved);
    check("spurious.busy", busy, 1'b0);
    check("spurious.mm_enable", mm_enable_p, 1'b0);

    do_job(rand_n(), rand_n(), rand_n(), "rand_full_a", -1, ops);
    do_job(rand_n(), rand_n(), rand_n() | N'(1), "rand_full_b", -1, ops);
    do_job(rand_n(), rand_n(), N'($urandom_range(2, 1000)), "rand_small_mod", -1, ops);

    @(negedge clk);
    b_in = rand_n(); e_in = rand_n() >> 1; m_in = rand_n() | N'(1); start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.result", result, '0);
    check("abort.mm_enable", mm_enable_p, 1'b0);
    check("abort.mm_a", mm_a, '0);
    check("abort.mm_m", mm_m, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done_irq_p || mm_enable_p || result != '0) bad = 1'b1;
    end
    check("abort.late_product_ignored", bad, 1'b0);
    do_job(N'(3), N'(3), N'(7), "after_abort", -1, ops);
    check("after_abort.value", result, N'(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Square-and-multiply modular exponentiation controller: computes result = base^exp mod m. It sits directly upstream of the interleaved modular multiplier. It feeds every operand pair to the multiplier and consumes every product the multiplier returns. The multiplier is driven through a dedicated mm_* port group, and the integration top wires that group to the multiplier instance.

## Interface
- NBITS, 256, operand/modulus width (base, m, result, multiplier operands)
- EBITS, NBITS, exponent width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start_p  in  1  one-cycle start pulse; sampled only in IDLE
- base  in  NBITS  base operand, latched on accepted start_p
- exp  in  EBITS  exponent, latched on accepted start_p
- m  in  NBITS  modulus, latched on accepted start_p
- result  out  NBITS  final value, held until next accepted start_p
- busy  out  1  high from the cycle after an accepted start until done_irq_p
- err  out  1  modulus-zero flag, valid with done_irq_p, held until next start
- done_irq_p  out  1  one-cycle completion pulse
- mm_enable_p  out  1  one-cycle multiply request
- mm_a, mm_b, mm_m  out  NBITS  multiplier operands, stable from request until mm_done_p
- mm_y  in  NBITS  multiplier product, sampled on mm_done_p
- mm_done_p  in  1  multiplier completion pulse

## Operation
- Reset values: result=0, err=0, busy=0, done_irq_p=0, mm_enable_p=0, mm_a/mm_b/mm_m=0, state=IDLE.
- States: IDLE, REDUCE, SQR, MUL, FIN.
- IDLE with start_p=1:
  - If m==0: go to FIN with err=1 and result=0. No multiplier traffic.
  - Otherwise: latch the inputs, set R=1, set bit index i=EBITS-1, go to REDUCE.
- REDUCE: request base*1 mod m and store the product as Bred. Then go to SQR. This ensures operands are below m for any base.
- SQR: request R*R mod m and store the product in R.
  - If exp[i]==1: go to MUL.
  - Otherwise, if i==0: go to FIN; else decrement i and return to SQR.
- MUL: request R*Bred mod m and store the product in R. Then, if i==0, go to FIN; else decrement i and go to SQR.
- FIN: result<=R, pulse done_irq_p, go to IDLE.
- Every stored value comes from the multiplier, so m==1 yields 0 and exp==0 yields 1 mod m with no special case.
- Each request state handshake:
  - Assert mm_enable_p for exactly one cycle on entry.
  - Hold the operands.
  - Wait for mm_done_p.
  - mm_done_p outside a wait is ignored.
- start_p while busy is ignored. Latched inputs do not change mid-operation.
- Deasserting rst_n mid-operation aborts immediately to the reset values. A product returned later is ignored because the state is IDLE.

## Timing
- Accepted start_p at cycle T: busy=1 at T+1, first mm_enable_p at T+1.
- If the multiplier latency is L (request cycle to mm_done_p cycle), the next request is issued the cycle after mm_done_p.
- Each multiply costs L+1 cycles.
- Operation count: 1 + EBITS + popcount(exp).
- done_irq_p asserts the cycle after the final mm_done_p. busy drops in the same cycle.
- m==0: done_irq_p at T+1 with err=1.
- A new start_p is accepted in the cycle after done_irq_p.

## Configuration
- MOD_EXP_CONST_TIME_EN defined:
  - MUL is entered after every SQR regardless of exp[i].
  - When exp[i]==0 the product is discarded and R is unchanged.
  - Operation count = 1 + 2*EBITS, independent of exp (timing side-channel hardening).
- Undefined: MUL is skipped for zero bits, as described above.

## Structure
- Package mod_exp_pkg: state enum type, NBITS default constant, operation-count helper function used by the bench.
- No internal sub-module; the FSM, bit counter and R/Bred registers live in mod_exp_ctrl.
- The multiplier is instantiated beside this block in the integration top, not inside it.

## Test plan
All cases use NBITS=256 with a multiplier model of fixed latency.
- Known answer: base=4, exp=13, m=497 -> result=445, err=0, mm_enable_p count 260 (macro: 513).
- Unreduced base: base=15, exp=2, m=10 -> result=5. Edge cases: exp=0, m=10 -> result=1; base=7, exp=5, m=1 -> result=0.
- Zero modulus: m=0 -> done_irq_p at T+1, err=1, result=0, no mm_enable_p.
- Protocol:
  - start_p pulsed during busy -> ignored, result unchanged from the first job.
  - Spurious mm_done_p while in IDLE -> no effect.
- Reset mid-run: rst_n low during SQR -> all outputs 0 immediately. A late mm_done_p is ignored. A subsequent start (base=3, exp=3, m=7) -> result=6.
